// File: rtl/sub_256_seq_if.sv
// Operand/result bundle for the chunked 256-bit subtractor.
// The master drives start and operands; the slave returns status and the difference.
interface sub_256_seq_if;
    logic         start;
    logic [256:1] A;
    logic [256:1] B;
    logic         bin;
    logic         busy;
    logic         done;
    logic [256:1] D;
    logic         bout;
    logic         zero;

    modport master (output start, A, B, bin, input busy, done, D, bout, zero);
    modport slave  (input start, A, B, bin, output busy, done, D, bout, zero);
endinterface

// File: rtl/sub_256_seq.sv
// Sequential 256-bit subtractor: D = A - B - bin, computed CHUNK bits per cycle
// with the borrow rippling through a register between chunks.
module sub_256_seq #(
    parameter int CHUNK = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    sub_256_seq_if.slave   bus
);
    localparam int NCHUNK = 256 / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);
    // Only chunk 0 exists when CHUNK is 256, so the base offset is always 0 there.
    localparam logic [7:0] CHUNK_B = (CHUNK >= 256) ? 8'd0 : 8'(CHUNK);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            brw_q, brw_d;
    logic [255:0]    a_q, a_d;
    logic [255:0]    b_q, b_d;
    logic [255:0]    d_q, d_d;
    logic            bout_q, bout_d;
    logic            zero_q, zero_d;

    logic [7:0]       base;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   diff;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        a_d     = a_q;
        b_d     = b_q;
        d_d     = d_q;
        bout_d  = bout_q;
        zero_d  = zero_q;

        base    = 8'(cnt_q) * CHUNK_B;
        a_chunk = a_q[base +: CHUNK];
        b_chunk = b_q[base +: CHUNK];
        diff    = {1'b0, a_chunk} - {1'b0, b_chunk} - (CHUNK + 1)'(brw_q);

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    a_d     = bus.A;
                    b_d     = bus.B;
                    brw_d   = bus.bin;
                    cnt_d   = '0;
                    d_d     = '0;
                    bout_d  = 1'b0;
                    zero_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                d_d[base +: CHUNK] = diff[CHUNK-1:0];
                brw_d              = diff[CHUNK];
                if (cnt_q == LAST) begin
                    // Last chunk: D is now complete, so flags are taken from it directly.
                    state_d = DONE;
                    cnt_d   = '0;
                    bout_d  = diff[CHUNK];
                    zero_d  = (d_d == '0);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.D    = d_q;
    assign bus.bout = bout_q;
    assign bus.zero = zero_q;
endmodule

// File: tb/tb_sub_256_seq.sv
// Directed and randomized checks of sub_256_seq for CHUNK = 4, 32 and 256,
// all three instances sharing the same clock, reset and operand drive.
module tb_sub_256_seq;
    logic         clk;
    logic         rst_n_r;
    logic         start_r;
    logic [256:1] a_r;
    logic [256:1] b_r;
    logic         bin_r;

    int checks;
    int errors;

    sub_256_seq_if if4 ();
    sub_256_seq_if if32 ();
    sub_256_seq_if if256 ();

    assign if4.start   = start_r;
    assign if4.A       = a_r;
    assign if4.B       = b_r;
    assign if4.bin     = bin_r;
    assign if32.start  = start_r;
    assign if32.A      = a_r;
    assign if32.B      = b_r;
    assign if32.bin    = bin_r;
    assign if256.start = start_r;
    assign if256.A     = a_r;
    assign if256.B     = b_r;
    assign if256.bin   = bin_r;

    sub_256_seq #(.CHUNK(4))   dut4   (.clk(clk), .rst_n(rst_n_r), .bus(if4));
    sub_256_seq #(.CHUNK(32))  dut32  (.clk(clk), .rst_n(rst_n_r), .bus(if32));
    sub_256_seq #(.CHUNK(256)) dut256 (.clk(clk), .rst_n(rst_n_r), .bus(if256));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [256:0] obs, input logic [256:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [256:1] a, input logic [256:1] b, input logic bin);
        a_r     = a;
        b_r     = b;
        bin_r   = bin;
        start_r = 1'b1;
    endtask

    // Counts edges from the accepting edge (1) until done is seen on the CHUNK=32 instance.
    task automatic waitDone(input bit scramble, output int lat);
        lat = 0;
        for (int k = 1; k <= 80; k++) begin
            tick();
            if (if32.done) begin
                lat = k;
                break;
            end
            if (scramble) begin
                start_r = 1'($urandom_range(0, 1));
                a_r     = {8{$urandom}};
                b_r     = {8{$urandom}};
                bin_r   = 1'($urandom_range(0, 1));
            end else begin
                start_r = 1'b0;
            end
        end
    endtask

    task automatic runOp32(input string tag, input logic [256:1] a, input logic [256:1] b,
                           input logic bin, input logic [256:1] exp_d, input logic exp_bout,
                           input logic exp_zero);
        int lat;
        applyStimulus(a, b, bin);
        waitDone(1'b0, lat);
        start_r = 1'b0;
        checkOutput({tag, "_latency"}, 257'(lat), 257'(9));
        checkOutput({tag, "_D"}, 257'(if32.D), 257'(exp_d));
        checkOutput({tag, "_bout"}, 257'(if32.bout), 257'(exp_bout));
        checkOutput({tag, "_zero"}, 257'(if32.zero), 257'(exp_zero));
    endtask

    initial begin
        int            lat;
        int            done_seen;
        int            lat4, lat32, lat256;
        logic [256:1]  d4, d32, d256;
        logic          bo4, bo32, bo256;
        logic [256:1]  ra, rb;
        logic          rbin;
        logic [256:0]  ref_diff;

        checks  = 0;
        errors  = 0;
        rst_n_r = 1'b0;
        start_r = 1'b1;
        a_r     = 256'd11;
        b_r     = 256'd3;
        bin_r   = 1'b0;

        // Reset wins over a pending start.
        tick();
        tick();
        checkOutput("reset_busy", 257'(if32.busy), 257'(0));
        checkOutput("reset_done", 257'(if32.done), 257'(0));
        checkOutput("reset_D", 257'(if32.D), 257'(0));
        checkOutput("reset_bout", 257'(if32.bout), 257'(0));
        checkOutput("reset_zero", 257'(if32.zero), 257'(0));

        // First cycle out of reset accepts start.
        rst_n_r = 1'b1;
        runOp32("small", 256'd5, 256'd3, 1'b0, 256'd2, 1'b0, 1'b0);

        tick();
        checkOutput("done_pulse", 257'(if32.done), 257'(0));
        tick();
        tick();
        checkOutput("idle_hold_D", 257'(if32.D), 257'(2));

        runOp32("borrow_all", 256'd0, 256'd1, 1'b0, {256{1'b1}}, 1'b1, 1'b0);
        runOp32("zero_res", {1'b1, 255'd0}, {1'b0, {255{1'b1}}}, 1'b1, 256'd0, 1'b0, 1'b1);
        tick();
        checkOutput("idle_hold_zero", 257'(if32.zero), 257'(1));

        // Back-to-back: start held through DONE, then noise on inputs during RUN.
        applyStimulus(256'd20, 256'd5, 1'b0);
        waitDone(1'b0, lat);
        checkOutput("b2b_first_latency", 257'(lat), 257'(9));
        checkOutput("b2b_first_D", 257'(if32.D), 257'(15));
        applyStimulus(256'd7, 256'd9, 1'b0);
        waitDone(1'b1, lat);
        start_r = 1'b0;
        checkOutput("b2b_second_latency", 257'(lat), 257'(9));
        checkOutput("b2b_second_D", 257'(if32.D), 257'({{255{1'b1}}, 1'b0}));
        checkOutput("b2b_second_bout", 257'(if32.bout), 257'(1));
        tick();
        checkOutput("b2b_back_idle_done", 257'(if32.done), 257'(0));
        checkOutput("b2b_back_idle_busy", 257'(if32.busy), 257'(0));

        // Reset while processing chunk 4 discards the operation.
        applyStimulus({256{1'b1}}, 256'd1, 1'b0);
        tick();
        start_r = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        checkOutput("midrun_busy", 257'(if32.busy), 257'(1));
        rst_n_r = 1'b0;
        tick();
        rst_n_r = 1'b1;
        checkOutput("midrun_rst_busy", 257'(if32.busy), 257'(0));
        checkOutput("midrun_rst_done", 257'(if32.done), 257'(0));
        checkOutput("midrun_rst_D", 257'(if32.D), 257'(0));
        checkOutput("midrun_rst_bout", 257'(if32.bout), 257'(0));
        done_seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (if32.done) done_seen++;
        end
        checkOutput("midrun_no_done", 257'(done_seen), 257'(0));
        runOp32("after_rst", 256'd1000, 256'd1, 1'b1, 256'd998, 1'b0, 1'b0);

        // Let every instance drain to IDLE before the sweep.
        for (int k = 0; k < 80; k++) tick();

        for (int v = 0; v < 6; v++) begin
            ra   = {8{$urandom}};
            rb   = {8{$urandom}};
            rbin = 1'($urandom_range(0, 1));
            if (v == 0) begin
                rb   = ra;
                rbin = 1'b1;
            end
            if (v == 1) begin
                rb   = {rb[256:129], ra[128:1]};
                rbin = 1'b0;
            end
            ref_diff = {1'b0, ra} - {1'b0, rb} - 257'(rbin);
            applyStimulus(ra, rb, rbin);
            lat4 = 0; lat32 = 0; lat256 = 0;
            d4 = '0; d32 = '0; d256 = '0;
            bo4 = 1'b0; bo32 = 1'b0; bo256 = 1'b0;
            for (int k = 1; k <= 80; k++) begin
                tick();
                start_r = 1'b0;
                if (if4.done && lat4 == 0) begin
                    lat4 = k; d4 = if4.D; bo4 = if4.bout;
                end
                if (if32.done && lat32 == 0) begin
                    lat32 = k; d32 = if32.D; bo32 = if32.bout;
                end
                if (if256.done && lat256 == 0) begin
                    lat256 = k; d256 = if256.D; bo256 = if256.bout;
                end
            end
            checkOutput($sformatf("rand%0d_c4_latency", v), 257'(lat4), 257'(65));
            checkOutput($sformatf("rand%0d_c4_D", v), 257'(d4), 257'(ref_diff[255:0]));
            checkOutput($sformatf("rand%0d_c4_bout", v), 257'(bo4), 257'(ref_diff[256]));
            checkOutput($sformatf("rand%0d_c32_latency", v), 257'(lat32), 257'(9));
            checkOutput($sformatf("rand%0d_c32_D", v), 257'(d32), 257'(ref_diff[255:0]));
            checkOutput($sformatf("rand%0d_c32_bout", v), 257'(bo32), 257'(ref_diff[256]));
            checkOutput($sformatf("rand%0d_c256_latency", v), 257'(lat256), 257'(2));
            checkOutput($sformatf("rand%0d_c256_D", v), 257'(d256), 257'(ref_diff[255:0]));
            checkOutput($sformatf("rand%0d_c256_bout", v), 257'(bo256), 257'(ref_diff[256]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
